// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath width, canonical NOP encoding and
// the {PC, instruction} record carried by the fetch stage.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/adder.sv
// Plain modular adder shared by the datapath (PC+4, branch targets).
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {PC, instruction} entries; flush beats push/pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Decoupled fetch stage: credit-limited requests to a variable-latency IMEM,
// in-order responses buffered in a prefetch FIFO, redirect flush with drop count.
module fetch_prefetch
    import riscv_pkg::*;
#(
    parameter int              XLEN      = riscv_pkg::XLEN,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            InstrValidF
);

    localparam int OW = $clog2(MAX_OUTST + 2);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] target;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   drop;
    logic [OW-1:0]   outst_redirect;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            fire;
    logic            push;
    logic            pop;
    logic            unused_target_lsbs;
    fetch_entry_t    head;
    fetch_entry_t    din;

    assign target             = {PCTargetE[XLEN-1:2], 2'b00};
    assign unused_target_lsbs = ^PCTargetE[1:0];

    // Handshake: the address is offered while imem_req is high and is consumed
    // on a cycle with imem_req && imem_gnt; each consumed request is answered by
    // exactly one imem_rvalid pulse, in order, at least one cycle later.
    // Credits (FIFO slots not yet claimed) keep responses from overflowing.
    assign imem_req  = ((int'(count) + int'(outst)) < DEPTH) && (int'(outst) < MAX_OUTST)
                       && !PCSrcE && !rst;
    assign imem_addr = fpc;
    assign fire      = imem_req && imem_gnt;

    // Responses still owed for pre-redirect requests are dropped, never pushed.
    assign push = imem_rvalid && (drop == '0) && !PCSrcE;
    assign pop  = !empty && !StallF && !PCSrcE;
    assign din  = '{pc: rpc, instr: imem_rdata};

    assign outst_redirect = outst + OW'(imem_gnt) - OW'(imem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            outst <= '0;
            drop  <= '0;
        end else if (PCSrcE) begin
            fpc   <= target;
            rpc   <= target;
            outst <= outst_redirect;
            drop  <= outst_redirect;
        end else begin
            if (fire) fpc <= fpc + PC_STEP;
            if (push) rpc <= rpc + PC_STEP;
            outst <= outst + OW'(fire) - OW'(imem_rvalid);
            if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (PCSrcE),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // When empty, PCF shows the PC the next accepted response will carry.
    assign InstrValidF = !empty;
    assign InstrF      = empty ? INSTR_NOP : head.instr;
    assign PCF         = empty ? rpc : head.pc;

    adder #(
        .WIDTH (XLEN)
    ) u_pc_plus4 (
        .a (PCF),
        .b (PC_STEP),
        .y (PCPlus4F)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_outst_max:   assert property (@(posedge clk) disable iff (rst) int'(outst) <= MAX_OUTST);
    a_drop_le:     assert property (@(posedge clk) disable iff (rst) drop <= outst);

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a behavioural in-order instruction memory.
module tb_fetch_prefetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls and state
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          rand_gnt  = 1'b0;
    bit          force_gnt = 1'b0;
    int          cyc       = 0;
    int          last_ready = 0;
    int          r;
    logic [31:0] pend_addr[$];
    int          pend_ready[$];

    // Scoreboard: next PC decode must see
    logic [31:0] exp_pc;
    int          consumed;

    fetch_prefetch #(
        .XLEN      (32),
        .DEPTH     (4),
        .MAX_OUTST (2),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallF      (StallF),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory: decides gnt/rvalid 2ns after negedge, books them 2ns later.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    end

    always begin
        @(negedge clk);
        #2;
        imem_gnt    = !rst && (force_gnt || (imem_req && (!rand_gnt || ($urandom_range(0, 1) == 1))));
        imem_rvalid = !rst && (pend_addr.size() > 0) && (pend_ready[0] <= cyc);
        imem_rdata  = imem_rvalid ? instr_of(pend_addr[0]) : 32'hDEAD_BEEF;
        #2;
        if (rst) begin
            pend_addr.delete();
            pend_ready.delete();
            last_ready = 0;
        end else begin
            if (imem_rvalid) begin
                void'(pend_addr.pop_front());
                void'(pend_ready.pop_front());
            end
            if (imem_gnt && (imem_req || PCSrcE)) begin
                r = cyc + $urandom_range(lat_min, lat_max);
                if (r < last_ready) r = last_ready;
                last_ready = r;
                pend_addr.push_back(imem_addr);
                pend_ready.push_back(r);
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1; PCSrcE = 1'b0; StallF = 1'b0; PCTargetE = 32'h0;
        repeat (2) @(negedge clk);
        #3;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++;
        if (InstrValidF !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", InstrValidF); end
        n_checks++;
        if (InstrF !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", InstrF, NOP); end
        n_checks++;
        if (PCF !== RESET_PC) begin n_fail++; $display("FAIL reset_pcf: got %h want %h", PCF, RESET_PC); end
        n_checks++;
        if (PCPlus4F !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL reset_pcplus4: got %h want %h", PCPlus4F, RESET_PC + 32'd4); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        rst = 1'b0;
        exp_pc = RESET_PC;
        for (int k = 0; k < 14; k++) begin
            #3;
            if (k == 0) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                    n_fail++; $display("FAIL first_req: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (InstrValidF !== 1'b0) begin n_fail++; $display("FAIL no_bypass: valid=%b want 0", InstrValidF); end
            end
            if (k >= 2) begin
                n_checks++;
                if (InstrValidF !== 1'b1) begin n_fail++; $display("FAIL throughput k=%0d: valid=%b want 1", k, InstrValidF); end
            end
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL stream: PCF=%h InstrF=%h want PCF=%h InstrF=%h", PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int pops;
        for (int k = 0; k < 6; k++) begin
            StallF = 1'b1;
            #3;
            n_checks++;
            if (InstrValidF !== 1'b1 || PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                n_fail++; $display("FAIL stall_hold k=%0d: valid=%b PCF=%h InstrF=%h want 1 %h %h", k, InstrValidF, PCF, InstrF, exp_pc, instr_of(exp_pc));
            end
            if (k == 5) begin
                n_checks++;
                if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req: req=%b want 0", imem_req); end
            end
            @(negedge clk);
        end
        StallF = 1'b0;
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL stall_drain: PCF=%h InstrF=%h want PCF=%h InstrF=%h", PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops != 12) begin n_fail++; $display("FAIL stall_drain_rate: pops=%0d want 12", pops); end
    endtask

    task automatic test_redirect();
        bit found;
        bit seen_req;
        int pops;
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pend_addr.size() == 2 && pend_ready[0] > cyc) begin
                found = 1'b1;
            end else begin
                #3;
                if (InstrValidF && !StallF && !PCSrcE) begin
                    n_checks++;
                    if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                        n_fail++; $display("FAIL redir_pre: PCF=%h InstrF=%h want PCF=%h", PCF, InstrF, exp_pc);
                    end
                    exp_pc += 32'd4;
                end
                @(negedge clk);
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL redir_setup: outstanding=%0d want 2", pend_addr.size()); end
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
        #3;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_low: req=%b want 0", imem_req); end
        exp_pc = 32'h0000_0100;
        @(negedge clk);
        PCSrcE = 1'b0;
        seen_req = 1'b0;
        pops = 0;
        for (int k = 0; k < 30 && pops < 3; k++) begin
            #3;
            if (k == 0) begin
                n_checks++;
                if (InstrValidF !== 1'b0 || PCF !== 32'h100) begin
                    n_fail++; $display("FAIL redir_flush: valid=%b PCF=%h want 0 00000100", InstrValidF, PCF);
                end
            end
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                n_checks++;
                if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: addr=%h want 00000100", imem_addr); end
            end
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL redir_stream: PCF=%h InstrF=%h want PCF=%h InstrF=%h", PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops < 3) begin n_fail++; $display("FAIL redir_progress: pops=%0d want 3", pops); end
    endtask

    task automatic test_redirect_coincident();
        bit found;
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pend_addr.size() == 1 && pend_ready[0] <= cyc && imem_req) begin
                found = 1'b1;
            end else begin
                #3;
                if (InstrValidF && !StallF && !PCSrcE) begin
                    n_checks++;
                    if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                        n_fail++; $display("FAIL coinc_pre: PCF=%h InstrF=%h want PCF=%h", PCF, InstrF, exp_pc);
                    end
                    exp_pc += 32'd4;
                end
                @(negedge clk);
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL coinc_setup: no cycle with 1 outstanding and a response"); end
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0203; force_gnt = 1'b1;
        #3;
        exp_pc = 32'h0000_0200;
        @(negedge clk);
        PCSrcE = 1'b0; force_gnt = 1'b0;
        #3;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL coinc_resume: req=%b addr=%h want 1 00000200", imem_req, imem_addr);
        end
        n_checks++;
        if (InstrValidF !== 1'b0 || PCF !== 32'h200 || PCPlus4F !== 32'h204) begin
            n_fail++; $display("FAIL coinc_empty: valid=%b PCF=%h PCPlus4F=%h want 0 00000200 00000204", InstrValidF, PCF, PCPlus4F);
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (InstrValidF !== 1'b0) begin n_fail++; $display("FAIL coinc_drop: valid=%b PCF=%h want valid 0", InstrValidF, PCF); end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            #3;
            if (k == 0) begin
                n_checks++;
                if (InstrValidF !== 1'b1) begin n_fail++; $display("FAIL coinc_first: valid=%b want 1", InstrValidF); end
            end
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL coinc_stream: PCF=%h InstrF=%h want PCF=%h InstrF=%h", PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int pops;
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        #3;
        exp_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcE = 1'b0;
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (k == 0) begin
                n_checks++;
                if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
                    n_fail++; $display("FAIL wrap_pc: PCF=%h PCPlus4F=%h want fffffffc 00000000", PCF, PCPlus4F);
                end
            end
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL wrap_stream: PCF=%h InstrF=%h want PCF=%h InstrF=%h", PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops < 6) begin n_fail++; $display("FAIL wrap_progress: pops=%0d want at least 6", pops); end
    endtask

    task automatic test_random();
        bit redir;
        rand_gnt = 1'b1; lat_min = 1; lat_max = 5;
        consumed = 0;
        for (int k = 0; k < 400; k++) begin
            StallF    = ($urandom_range(0, 99) < 30);
            redir     = ($urandom_range(0, 99) < 4);
            PCSrcE    = redir;
            PCTargetE = redir ? $urandom_range(0, 32'h0000_FFFF) : 32'h0;
            #3;
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL random_stream k=%0d: PCF=%h InstrF=%h want PCF=%h InstrF=%h", k, PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
                consumed++;
            end
            if (redir) exp_pc = PCTargetE & 32'hFFFF_FFFC;
            @(negedge clk);
        end
        PCSrcE = 1'b0; StallF = 1'b0; rand_gnt = 1'b0; lat_min = 1; lat_max = 1;
        n_checks++;
        if (consumed < 50) begin n_fail++; $display("FAIL random_progress: consumed=%0d want at least 50", consumed); end
    endtask

    task automatic test_reset_midstream();
        int pops;
        for (int k = 0; k < 14; k++) begin
            StallF = 1'b1;
            #3;
            if (k == 13) begin
                n_checks++;
                if (imem_req !== 1'b0 || InstrValidF !== 1'b1) begin
                    n_fail++; $display("FAIL midrst_full: req=%b valid=%b want 0 1", imem_req, InstrValidF);
                end
            end
            @(negedge clk);
        end
        rst = 1'b1; StallF = 1'b0;
        #3;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: req=%b want 0", imem_req); end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC;
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            #3;
            if (k == 0) begin
                n_checks++;
                if (InstrValidF !== 1'b0 || PCF !== RESET_PC) begin
                    n_fail++; $display("FAIL midrst_out: valid=%b PCF=%h want 0 %h", InstrValidF, PCF, RESET_PC);
                end
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                    n_fail++; $display("FAIL midrst_resume: req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
                end
            end
            if (InstrValidF && !StallF && !PCSrcE) begin
                n_checks++;
                if (PCF !== exp_pc || InstrF !== instr_of(exp_pc)) begin
                    n_fail++; $display("FAIL midrst_stream: PCF=%h InstrF=%h want PCF=%h InstrF=%h", PCF, InstrF, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops != 6) begin n_fail++; $display("FAIL midrst_rate: pops=%0d want 6", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_coincident();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-cycle fetch stage: decouples PC generation from a variable-latency instruction memory using a request/grant/response handshake and a prefetch FIFO of {PC, instruction} entries. It sits between the branch-resolution logic in EX and the IF/ID pipeline register, and presents a valid-qualified instruction to decode. It honours StallF without losing in-flight fetches and flushes cleanly on a PCSrcE redirect.

## Interface
- XLEN, riscv_pkg::XLEN, address/PC width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- MAX_OUTST, 2, maximum granted-but-unanswered requests; 1..DEPTH
- RESET_PC, 0, first fetch address

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- PCSrcE  in  1  redirect: take PCTargetE
- PCTargetE  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- StallF  in  1  hold current output entry
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  request address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (in order, ≥1 cycle after gnt)
- imem_rdata  in  32  response instruction
- InstrF  out  32  head instruction; INSTR_NOP when empty
- PCF  out  XLEN  head PC; next expected PC when empty
- PCPlus4F  out  XLEN  PCF + 4, mod 2^XLEN
- InstrValidF  out  1  head entry valid

## Operation
- State: fpc (next request address), rpc (PC of next accepted response), outst counter, drop counter, FIFO.
- imem_req = (count + outst < DEPTH) && (outst < MAX_OUTST) && !PCSrcE && !rst; imem_addr = fpc. Credit scheme guarantees FIFO never overflows.
- req && gnt: fpc += 4, outst += 1. Address changes only after a grant or on redirect.
- rvalid: outst −= 1. If drop > 0 (or PCSrcE this cycle): discard, decrement drop. Else push {rpc, rdata}, rpc += 4.
- Pop when InstrValidF && !StallF && !PCSrcE. Push and pop in the same cycle are allowed at any occupancy.
- Redirect (PCSrcE=1), priority over StallF and any pop: FIFO flushed; fpc, rpc ← {PCTargetE[XLEN-1:2],2'b00}; drop ← outst + gnt − rvalid, where gnt/rvalid are that cycle's values and this cycle's rvalid is itself discarded.
- Redirect while drop > 0: drop accumulates as above; no stale response may ever reach the FIFO.
- PC arithmetic wraps modulo 2^XLEN.

## Timing
- Reset (rst=1 at edge): FIFO empty, outst=0, drop=0, fpc=rpc=RESET_PC. Outputs after reset: imem_req=0 during rst, InstrValidF=0, InstrF=INSTR_NOP (32'h00000013), PCF=RESET_PC, PCPlus4F=RESET_PC+4.
- Mid-operation reset discards everything. The memory shares rst, so no response arrives for a pre-reset request.
- Pushed entry is visible at outputs the cycle after rvalid; no bypass.
- Best-case latency: gnt at cycle t, rvalid t+1, InstrValidF t+2. Redirect at t: req to target at t+1.
- Steady state, with 1-cycle memory and MAX_OUTST≥2: one instruction per cycle.
- StallF with empty FIFO has no effect on prefetching; fetching continues until credits run out.

## Structure
- riscv_pkg: XLEN, INSTR_NOP, typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, with push, pop, flush (flush wins), count, empty, full. The counter width must also encode DEPTH.
- PCPlus4F uses the existing adder module.
- Assertions: no push when full; outst ≤ MAX_OUTST; drop ≤ outst.

## Test plan
- Reset, 1-cycle memory, RESET_PC=0 → requests 0,4,8,…; InstrValidF rises 2 cycles after the first gnt; PCF/InstrF match memory words in order, one per cycle.
- StallF held 6 cycles, DEPTH=4, MAX_OUTST=2 → count reaches 4, imem_req drops, head stays constant; release → entries drain in order with no loss or duplicate.
- Redirect to 0x100 while 2 requests outstanding → next 2 rvalids discarded, next request addr 0x100, first valid PCF=0x100, no stale instruction appears.
- Redirect with PCTargetE=0x203 coincident with rvalid and gnt → that response dropped, drop=outst+1−1, fetch resumes at 0x200.
- Random gnt/rvalid delays 1–5 cycles plus random StallF and redirects, checked against a reference PC stream → exact sequence match, FIFO never overflows.
- rst asserted mid-stream with FIFO full → next cycle InstrValidF=0, PCF=RESET_PC, imem_req resumes at RESET_PC after rst drops.
